// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU command sequencer.
package alu_seq_pkg;

  localparam int unsigned OP_A_W   = 3;
  localparam int unsigned OP_B_W   = 2;
  localparam int unsigned DATA_W   = 5;
  localparam int unsigned TAG_BITS = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} seq_state_e;

  typedef struct packed {
    logic [DATA_W-1:0]   a;
    logic [DATA_W-1:0]   b;
    logic [OP_A_W-1:0]   a_op;
    logic [OP_B_W-1:0]   b_op;
    logic                a_en;
    logic                b_en;
    logic [TAG_BITS-1:0] tag;
  } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO between the front end and the sequencer FSM; no bypass path.
module alu_cmd_fifo
  import alu_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push_i,
  input  alu_cmd_t wdata_i,
  input  logic     pop_i,
  output alu_cmd_t rdata_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  alu_cmd_t        mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({push_i, pop_i})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; entries are only read when count says they are valid.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issues buffered commands to the ALU one at a time and returns tagged results.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH   = DATA_W,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TAG_W   = TAG_BITS,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [WIDTH-1:0]  cmd_a,
  input  logic [WIDTH-1:0]  cmd_b,
  input  logic [2:0]        cmd_a_op,
  input  logic [1:0]        cmd_b_op,
  input  logic              cmd_a_en,
  input  logic              cmd_b_en,
  input  logic [TAG_W-1:0]  cmd_tag,
  output logic [WIDTH-1:0]  alu_A,
  output logic [WIDTH-1:0]  alu_B,
  output logic              alu_en,
  output logic              alu_a_en,
  output logic              alu_b_en,
  output logic [2:0]        alu_a_op,
  output logic [1:0]        alu_b_op,
  input  logic [WIDTH:0]    alu_C,
  input  logic              alu_error_flag,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTH:0]    rsp_c,
  output logic              rsp_err,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              busy,
  output logic [7:0]        err_cnt
);

  seq_state_e       state_q, state_d;
  alu_cmd_t         cmd_q, cmd_d;
  logic             alu_en_q, alu_en_d;
  logic [2:0]       lat_cnt_q, lat_cnt_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH:0]   rsp_c_q, rsp_c_d;
  logic             rsp_err_q, rsp_err_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  alu_cmd_t fifo_wdata, fifo_rdata;
  logic     fifo_push, fifo_pop, fifo_full, fifo_empty;

  always_comb begin
    fifo_wdata      = '0;
    fifo_wdata.a    = cmd_a;
    fifo_wdata.b    = cmd_b;
    fifo_wdata.a_op = cmd_a_op;
    fifo_wdata.b_op = cmd_b_op;
    fifo_wdata.a_en = cmd_a_en;
    fifo_wdata.b_en = cmd_b_en;
    fifo_wdata.tag  = cmd_tag;
  end

  assign fifo_push = cmd_valid && cmd_ready;

  alu_cmd_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (fifo_push),
    .wdata_i(fifo_wdata),
    .pop_i  (fifo_pop),
    .rdata_o(fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    alu_en_d    = 1'b0;
    lat_cnt_d   = lat_cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_c_d     = rsp_c_q;
    rsp_err_d   = rsp_err_q;
    rsp_tag_d   = rsp_tag_q;
    err_cnt_d   = err_cnt_q;
    fifo_pop    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cmd_d    = fifo_rdata;
          alu_en_d = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        lat_cnt_d = 3'(ALU_LAT);
        state_d   = WAIT;
      end
      WAIT: begin
        lat_cnt_d = lat_cnt_q - 3'd1;
        if (lat_cnt_q == 3'd1) begin
          rsp_valid_d = 1'b1;
          rsp_c_d     = alu_C;
          rsp_err_d   = alu_error_flag;
          rsp_tag_d   = cmd_q.tag;
          if (alu_error_flag && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // Retire the response and start the next command on the same edge.
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            cmd_d    = fifo_rdata;
            alu_en_d = 1'b1;
            state_d  = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      alu_en_q    <= 1'b0;
      lat_cnt_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_c_q     <= '0;
      rsp_err_q   <= 1'b0;
      rsp_tag_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      alu_en_q    <= alu_en_d;
      lat_cnt_q   <= lat_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_c_q     <= rsp_c_d;
      rsp_err_q   <= rsp_err_d;
      rsp_tag_q   <= rsp_tag_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign cmd_ready = !fifo_full;
  assign alu_A     = cmd_q.a;
  assign alu_B     = cmd_q.b;
  assign alu_a_op  = cmd_q.a_op;
  assign alu_b_op  = cmd_q.b_op;
  assign alu_a_en  = cmd_q.a_en;
  assign alu_b_en  = cmd_q.b_en;
  assign alu_en    = alu_en_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_c     = rsp_c_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_tag   = rsp_tag_q;
  assign err_cnt   = err_cnt_q;
  assign busy      = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench with an ALU stub and a response scoreboard; second instance covers ALU_LAT=3.
module tb_alu_cmd_sequencer;

  localparam int W  = 5;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0, cmd_ready;
  logic [W-1:0]  cmd_a = '0, cmd_b = '0;
  logic [2:0]    cmd_a_op = '0;
  logic [1:0]    cmd_b_op = '0;
  logic          cmd_a_en = 1'b0, cmd_b_en = 1'b0;
  logic [TW-1:0] cmd_tag = '0;
  logic [W-1:0]  alu_A, alu_B;
  logic          alu_en, alu_a_en, alu_b_en;
  logic [2:0]    alu_a_op;
  logic [1:0]    alu_b_op;
  logic [W:0]    alu_C;
  logic          alu_error_flag;
  logic          rsp_valid, rsp_ready = 1'b0, rsp_err, busy;
  logic [W:0]    rsp_c;
  logic [TW-1:0] rsp_tag;
  logic [7:0]    err_cnt;

  logic          cmd3_valid = 1'b0, cmd3_ready;
  logic [W-1:0]  alu3_A, alu3_B;
  logic          alu3_en, alu3_a_en, alu3_b_en;
  logic [2:0]    alu3_a_op;
  logic [1:0]    alu3_b_op;
  logic [W:0]    alu3_C;
  logic          alu3_error_flag;
  logic          rsp3_valid, rsp3_err, busy3;
  logic [W:0]    rsp3_c;
  logic [TW-1:0] rsp3_tag;
  logic [7:0]    err3_cnt;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.WIDTH(W), .DEPTH(4), .TAG_W(TW), .ALU_LAT(1)) u_dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_a_op(cmd_a_op), .cmd_b_op(cmd_b_op),
    .cmd_a_en(cmd_a_en), .cmd_b_en(cmd_b_en), .cmd_tag(cmd_tag),
    .alu_A(alu_A), .alu_B(alu_B), .alu_en(alu_en), .alu_a_en(alu_a_en), .alu_b_en(alu_b_en),
    .alu_a_op(alu_a_op), .alu_b_op(alu_b_op), .alu_C(alu_C), .alu_error_flag(alu_error_flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_c(rsp_c), .rsp_err(rsp_err),
    .rsp_tag(rsp_tag), .busy(busy), .err_cnt(err_cnt)
  );

  alu_cmd_sequencer #(.WIDTH(W), .DEPTH(4), .TAG_W(TW), .ALU_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .cmd_valid(cmd3_valid), .cmd_ready(cmd3_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_a_op(cmd_a_op), .cmd_b_op(cmd_b_op),
    .cmd_a_en(cmd_a_en), .cmd_b_en(cmd_b_en), .cmd_tag(cmd_tag),
    .alu_A(alu3_A), .alu_B(alu3_B), .alu_en(alu3_en), .alu_a_en(alu3_a_en),
    .alu_b_en(alu3_b_en), .alu_a_op(alu3_a_op), .alu_b_op(alu3_b_op), .alu_C(alu3_C),
    .alu_error_flag(alu3_error_flag), .rsp_valid(rsp3_valid), .rsp_ready(1'b1),
    .rsp_c(rsp3_c), .rsp_err(rsp3_err), .rsp_tag(rsp3_tag), .busy(busy3), .err_cnt(err3_cnt)
  );

  // ALU stubs: result register loaded at the sampling edge, then ALU_LAT-1 delay stages.
  logic [W:0] c1_q, c3_q0, c3_q1, c3_q2;
  logic       e1_q, e3_q0, e3_q1, e3_q2;
  always @(posedge clk) begin
    if (alu_en) begin
      c1_q <= {1'b0, alu_A} + {1'b0, alu_B};
      e1_q <= (alu_a_op == 3'b111);
    end
    if (alu3_en) begin
      c3_q0 <= {1'b0, alu3_A} + {1'b0, alu3_B};
      e3_q0 <= (alu3_a_op == 3'b111);
    end
    c3_q1 <= c3_q0; c3_q2 <= c3_q1;
    e3_q1 <= e3_q0; e3_q2 <= e3_q1;
  end
  assign alu_C           = c1_q;
  assign alu_error_flag  = e1_q;
  assign alu3_C          = c3_q2;
  assign alu3_error_flag = e3_q2;

  int checks = 0, errors = 0, rsp_seen = 0;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  typedef struct {
    logic [W:0]    c;
    logic          err;
    logic [TW-1:0] tag;
  } exp_t;
  exp_t exp_q[$];

  // Scoreboard: both handshakes complete at the posedge following this negedge.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (cmd_valid && cmd_ready) begin
        e.c   = {1'b0, cmd_a} + {1'b0, cmd_b};
        e.err = (cmd_a_op == 3'b111);
        e.tag = cmd_tag;
        exp_q.push_back(e);
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("rsp_c", 32'(rsp_c), 32'(e.c));
          check("rsp_err", 32'(rsp_err), 32'(e.err));
          check("rsp_tag", 32'(rsp_tag), 32'(e.tag));
          rsp_seen++;
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] aop,
                      input logic [TW-1:0] tag);
    bit done = 1'b0;
    @(posedge clk);
    #1;
    cmd_a = a; cmd_b = b; cmd_a_op = aop; cmd_b_op = tag[1:0];
    cmd_a_en = 1'b1; cmd_b_en = tag[0]; cmd_tag = tag; cmd_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    cmd_valid = 1'b0;
    check("send_accept", 32'(done), 32'd1);
  endtask

  task automatic drain();
    bit idle = 1'b0;
    for (int i = 0; i < 5000 && !idle; i++) begin
      @(negedge clk);
      idle = (exp_q.size() == 0) && !busy && !rsp_valid;
    end
    check("drain_idle", 32'(idle), 32'd1);
  endtask

  initial begin
    int seen0;
    logic [W:0] held_c;

    // Reset values
    #3;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_alu_en", 32'(alu_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_alu_A", 32'(alu_A), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single command latency: accept edge 0, ISSUE after edge 1, response after edge 3
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    send(5'd3, 5'd4, 3'd0, 4'd1);
    @(negedge clk);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_alu_en_e0", 32'(alu_en), 32'd0);
    @(negedge clk);
    check("t1_alu_en_e1", 32'(alu_en), 32'd1);
    check("t1_alu_A", 32'(alu_A), 32'd3);
    check("t1_alu_B", 32'(alu_B), 32'd4);
    @(negedge clk);
    check("t1_alu_en_e2", 32'(alu_en), 32'd0);
    check("t1_rsp_valid_e2", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("t1_rsp_valid_e3", 32'(rsp_valid), 32'd1);
    check("t1_rsp_c", 32'(rsp_c), 32'd7);
    check("t1_rsp_tag", 32'(rsp_tag), 32'd1);
    drain();
    check("t1_err_cnt", 32'(err_cnt), 32'd0);

    // Burst with backpressure: FIFO fills while the first response is held
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    seen0 = rsp_seen;
    for (int i = 0; i < 5; i++) send(W'(i + 1), W'(2 * i + 3), 3'(i), TW'(i));
    @(negedge clk);
    check("t2_full_ready", 32'(cmd_ready), 32'd0);
    held_c = rsp_c;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t4_rsp_valid", 32'(rsp_valid), 32'd1);
      check("t4_rsp_c", 32'(rsp_c), 32'(held_c));
      check("t4_rsp_c_val", 32'(rsp_c), 32'd4);
      check("t4_rsp_tag", 32'(rsp_tag), 32'd0);
      check("t4_alu_en", 32'(alu_en), 32'd0);
      check("t4_no_pop", 32'(cmd_ready), 32'd0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    send(5'd6, 5'd13, 3'd5, 4'd5);
    drain();
    check("t2_rsp_count", 32'(rsp_seen - seen0), 32'd6);

    // Error path and saturation
    send(5'd1, 5'd2, 3'b111, 4'd6);
    send(5'd9, 5'd9, 3'b111, 4'd7);
    drain();
    check("t3_err_cnt_2", 32'(err_cnt), 32'd2);
    for (int i = 0; i < 300; i++) send(W'(i), W'(i + 7), 3'b111, TW'(i));
    drain();
    check("t3_err_cnt_sat", 32'(err_cnt), 32'hFF);

    // Reset while waiting on the ALU
    send(5'd10, 5'd11, 3'd0, 4'd9);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("t5_cmd_ready", 32'(cmd_ready), 32'd1);
    check("t5_rsp_valid", 32'(rsp_valid), 32'd0);
    check("t5_alu_en", 32'(alu_en), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_err_cnt", 32'(err_cnt), 32'd0);
    check("t5_alu_A", 32'(alu_A), 32'd0);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t5_no_stale_rsp", 32'(rsp_valid), 32'd0);
    end
    seen0 = rsp_seen;
    send(5'd12, 5'd13, 3'd2, 4'd10);
    drain();
    check("t5_rsp_count", 32'(rsp_seen - seen0), 32'd1);

    // ALU_LAT=3 instance: response registered at edge 5 after accept
    @(posedge clk);
    #1;
    cmd_a = 5'd31; cmd_b = 5'd1; cmd_a_op = 3'd0; cmd_tag = 4'd3; cmd3_valid = 1'b1;
    @(negedge clk);
    check("t6_cmd_ready", 32'(cmd3_ready), 32'd1);
    @(posedge clk);
    #1 cmd3_valid = 1'b0;
    for (int e = 0; e < 5; e++) begin
      @(negedge clk);
      check("t6_rsp_valid_early", 32'(rsp3_valid), 32'd0);
    end
    @(negedge clk);
    check("t6_rsp_valid_e5", 32'(rsp3_valid), 32'd1);
    check("t6_rsp_c", 32'(rsp3_c), 32'd32);
    check("t6_rsp_tag", 32'(rsp3_tag), 32'd3);
    check("t6_rsp_err", 32'(rsp3_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
